// File: rtl/AluCtrlSig_pkg.sv
// Shared fetch-stage types: the NOP word driven to decode when s2 is empty
// and the {instruction, PC+4} record carried through the fetch queue.
// No logic, no latency, no backpressure.
package AluCtrlSig_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc4;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with push/pop/flush; head is read combinationally.
// Latency: a pushed entry is visible at o_head the cycle after the push.
// Backpressure: none internally; the caller keeps occupancy within DEPTH
// (pushes when full without a pop, and pops when empty, are ignored).
// Ports: i_push/i_push_dat write, i_pop advance head, i_flush empty all,
//        o_head current head entry, o_count occupancy (0..DEPTH).
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = logic [31:0]
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  T                         i_push_dat,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output T                         o_head,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  T              r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic w_pop;
  logic w_push;

  // Push alongside a pop is legal even when full: the slot frees this edge.
  assign w_pop  = i_pop && (r_count != '0);
  assign w_push = i_push && ((r_count != FULL_CNT) || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once counted valid.
  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_push_dat;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction-fetch stage s1: owns the PC, issues imem requests, queues
// in-order responses and presents one word per cycle to decode (inst_s2/pc4_s2).
// Latency: a response reaches s2 on its own edge if the queue is empty and
// decode is not stalled, otherwise in FIFO order.
// Backpressure: requests stop once outstanding + queued reaches DEPTH;
// stall holds s2 while the queue keeps filling.
// Ports: imem_* request/response channel, redirect/redirect_pc from ex,
//        stall from decode, inst_s2/pc4_s2/valid_s2 to decode.
module inst_fetch_queue
  import AluCtrlSig_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] inst_s2,
  output logic [31:0] pc4_s2,
  output logic        valid_s2
);

  localparam int unsigned CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [31:0]   r_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_kill_cnt;
  logic [31:0]   r_inst_s2;
  logic [31:0]   r_pc4_s2;
  logic          r_valid_s2;

  logic [CW-1:0] w_q_count;
  logic [CW-1:0] w_tag_count;
  fetch_entry_t  w_q_head;
  fetch_entry_t  w_q_push_dat;
  logic [31:0]   w_tag_head;
  logic [31:0]   w_pc_next;
  logic [CW:0]   w_occ;
  logic          w_grant;
  logic          w_resp;
  logic          w_killing;
  logic          w_live;
  logic          w_q_empty;
  logic          w_bypass;
  logic          w_q_push;
  logic          w_q_pop;
  logic          w_tag_pop;

  // Credit: every request in flight already owns a queue slot.
  assign w_occ     = {1'b0, r_outstanding} + {1'b0, w_q_count};
  assign imem_req  = !rst && !redirect && (w_occ < DEPTH_W);
  assign imem_addr = r_pc;
  assign w_pc_next = r_pc + 32'd4;
  assign w_grant   = imem_req && imem_gnt;

  // A response with nothing outstanding (e.g. left over from before reset) is ignored.
  assign w_resp    = imem_rvalid && (r_outstanding != '0);
  assign w_killing = r_kill_cnt != '0;
  // A response in the redirect cycle is itself wrong-path.
  assign w_live    = w_resp && !w_killing && !redirect;

  assign w_q_empty    = w_q_count == '0;
  assign w_bypass     = w_live && w_q_empty && !stall;
  assign w_q_push     = w_live && !w_bypass;
  assign w_q_pop      = !redirect && !stall && !w_q_empty;
  // Killed responses had their tags flushed at redirect, so only live ones pop.
  assign w_tag_pop    = w_live && (w_tag_count != '0);
  assign w_q_push_dat = '{inst: imem_rdata, pc4: w_tag_head};

  fetch_fifo #(.DEPTH(DEPTH), .T(logic [31:0])) u_tag_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_grant),
    .i_push_dat (w_pc_next),
    .i_pop      (w_tag_pop),
    .i_flush    (redirect),
    .o_head     (w_tag_head),
    .o_count    (w_tag_count)
  );

  fetch_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_inst_queue (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_q_push),
    .i_push_dat (w_q_push_dat),
    .i_pop      (w_q_pop),
    .i_flush    (redirect),
    .o_head     (w_q_head),
    .o_count    (w_q_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_outstanding <= '0;
      r_kill_cnt    <= '0;
      r_inst_s2     <= NOP_INST;
      r_pc4_s2      <= '0;
      r_valid_s2    <= 1'b0;
    end else begin
      if (redirect)     r_pc <= redirect_pc;
      else if (w_grant) r_pc <= w_pc_next;

      case ({w_grant, w_resp})
        2'b10:   r_outstanding <= r_outstanding + CW'(1);
        2'b01:   r_outstanding <= r_outstanding - CW'(1);
        default: ;
      endcase

      // A new redirect recounts from what is still in flight; older kills are subsumed.
      if (redirect)                r_kill_cnt <= r_outstanding - CW'(w_resp);
      else if (w_resp && w_killing) r_kill_cnt <= r_kill_cnt - CW'(1);

      if (redirect) begin
        r_inst_s2  <= NOP_INST;
        r_valid_s2 <= 1'b0;
      end else if (stall) begin
        // hold s2
      end else if (!w_q_empty) begin
        r_inst_s2  <= w_q_head.inst;
        r_pc4_s2   <= w_q_head.pc4;
        r_valid_s2 <= 1'b1;
      end else if (w_live) begin
        r_inst_s2  <= imem_rdata;
        r_pc4_s2   <= w_tag_head;
        r_valid_s2 <= 1'b1;
      end else begin
        r_inst_s2  <= NOP_INST;
        r_valid_s2 <= 1'b0;
      end
    end
  end

  assign inst_s2  = r_inst_s2;
  assign pc4_s2   = r_pc4_s2;
  assign valid_s2 = r_valid_s2;

  property p_credit;
    @(posedge clk) disable iff (rst) w_occ <= DEPTH_W;
  endproperty
  a_credit: assert property (p_credit);

endmodule

// File: tb/tb_inst_fetch_queue.sv
module tb_inst_fetch_queue;
  import AluCtrlSig_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic [31:0] inst_s2;
  logic [31:0] pc4_s2;
  logic        valid_s2;

  always #5 clk = ~clk;

  inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .inst_s2     (inst_s2),
    .pc4_s2      (pc4_s2),
    .valid_s2    (valid_s2)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_true(input string name, input bit cond);
    checks++;
    if (!cond) begin
      errors++;
      $display("FAIL %s: condition false, expected true", name);
    end
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        redir;
    logic [31:0] rpc;
    logic        stl;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] inst;
    logic [31:0] pc4;
  } vec_t;

  function automatic vec_t mk(input logic gnt, input logic rv, input logic [31:0] rdata,
                              input logic redir, input logic [31:0] rpc, input logic stl,
                              input logic req, input logic [31:0] addr, input logic vld,
                              input logic [31:0] inst, input logic [31:0] pc4);
    vec_t v;
    v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.redir = redir; v.rpc = rpc; v.stl = stl;
    v.req = req; v.addr = addr; v.vld = vld; v.inst = inst; v.pc4 = pc4;
    return v;
  endfunction

  vec_t tbl [12];

  // ---------------- memory responder / stream model ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pend[$];
  int          cyc = 0;
  int          lat = 1;
  bit          gnt_toggle = 0;
  bit          inject_stale = 0;
  logic [31:0] exp_addr = 32'h0;
  int          grants = 0;
  int          words = 0;
  bit          last_granted;
  logic [31:0] last_gaddr;

  // One clock cycle: memory drives at negedge, grant is captured before the
  // edge, s2 is compared with the in-order address stream after the edge.
  task automatic tick();
    @(negedge clk);
    if (inject_stale) begin
      imem_rvalid  = 1'b1;
      imem_rdata   = 32'hdead_beef;
      inject_stale = 0;
    end else if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = pend[0].addr;
      void'(pend.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
    imem_gnt = gnt_toggle ? cyc[0] : 1'b1;
    #1;
    last_granted = imem_req && imem_gnt;
    last_gaddr   = imem_addr;
    if (last_granted) begin
      pend.push_back('{addr: imem_addr, due: cyc + lat});
      grants++;
    end
    @(posedge clk);
    #1;
    if (redirect) begin
      chk("redirect squash valid", 32'(valid_s2), 32'd0);
      chk("redirect squash inst", inst_s2, NOP_INST);
      exp_addr = redirect_pc;
    end else if (!stall) begin
      if (valid_s2) begin
        chk("stream inst", inst_s2, exp_addr);
        chk("stream pc4", pc4_s2, exp_addr + 32'd4);
        exp_addr = exp_addr + 32'd4;
        words++;
      end else begin
        chk("bubble inst", inst_s2, NOP_INST);
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    redirect = 1'b0; redirect_pc = 32'h0; stall = 1'b0;
    pend.delete();
    inject_stale = 0;
    @(posedge clk);
    #1;
    chk("reset req", 32'(imem_req), 32'd0);
    chk("reset addr", imem_addr, 32'h0);
    chk("reset valid", 32'(valid_s2), 32'd0);
    chk("reset inst", inst_s2, NOP_INST);
    chk("reset pc4", pc4_s2, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int occ;
    int max_occ;
    bit v_before;

    //            gnt rv rdata      rd rpc       st | req addr      vld inst      pc4
    tbl[0]  = mk(1, 0, 32'h0,     0, 32'h0,   0,   1, 32'h0,    0, 32'h0,   32'h0);
    tbl[1]  = mk(1, 1, 32'h0,     0, 32'h0,   0,   1, 32'h4,    1, 32'h0,   32'h4);
    tbl[2]  = mk(1, 1, 32'h4,     0, 32'h0,   0,   1, 32'h8,    1, 32'h4,   32'h8);
    tbl[3]  = mk(1, 1, 32'h8,     0, 32'h0,   0,   1, 32'hc,    1, 32'h8,   32'hc);
    tbl[4]  = mk(1, 0, 32'h0,     0, 32'h0,   0,   1, 32'h10,   0, 32'h0,   32'hc);
    tbl[5]  = mk(1, 0, 32'h0,     0, 32'h0,   0,   1, 32'h14,   0, 32'h0,   32'hc);
    tbl[6]  = mk(1, 0, 32'h0,     1, 32'h100, 0,   0, 32'h18,   0, 32'h0,   32'hc);
    tbl[7]  = mk(1, 1, 32'hc,     0, 32'h0,   0,   1, 32'h100,  0, 32'h0,   32'hc);
    tbl[8]  = mk(1, 1, 32'h10,    0, 32'h0,   0,   1, 32'h104,  0, 32'h0,   32'hc);
    tbl[9]  = mk(1, 1, 32'h14,    0, 32'h0,   0,   1, 32'h108,  0, 32'h0,   32'hc);
    tbl[10] = mk(1, 1, 32'h100,   0, 32'h0,   0,   1, 32'h10c,  1, 32'h100, 32'h104);
    tbl[11] = mk(1, 1, 32'h104,   0, 32'h0,   0,   1, 32'h110,  1, 32'h104, 32'h108);

    do_reset();

    // Streaming after reset, then redirect to 0x100 with three requests in flight.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      imem_gnt    = tbl[i].gnt;
      imem_rvalid = tbl[i].rv;
      imem_rdata  = tbl[i].rdata;
      redirect    = tbl[i].redir;
      redirect_pc = tbl[i].rpc;
      stall       = tbl[i].stl;
      #1;
      chk($sformatf("vec%0d req", i), 32'(imem_req), 32'(tbl[i].req));
      chk($sformatf("vec%0d addr", i), imem_addr, tbl[i].addr);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d valid", i), 32'(valid_s2), 32'(tbl[i].vld));
      chk($sformatf("vec%0d inst", i), inst_s2, tbl[i].inst);
      chk($sformatf("vec%0d pc4", i), pc4_s2, tbl[i].pc4);
    end

    // Stall from reset: exactly DEPTH grants, then requests stop; release drains in order.
    do_reset();
    lat = 1; gnt_toggle = 0; exp_addr = 32'h0; grants = 0;
    stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("stall%0d valid", i), 32'(valid_s2), 32'd0);
    end
    chk("stall grants", 32'(grants), 32'd4);
    chk("stall req off", 32'(imem_req), 32'd0);
    stall = 1'b0;
    words = 0;
    repeat (4) tick();
    chk("stall drain words", 32'(words), 32'd4);

    // Redirect together with stall and a response in the same cycle.
    lat = 3;
    repeat (8) tick();
    v_before = valid_s2;
    stall = 1'b1;
    tick();
    if (v_before) chk("stall hold inst", inst_s2, exp_addr - 32'd4);
    for (int g = 0; g < 20 && !(pend.size() > 0 && pend[0].due <= cyc); g++) tick();
    chk_true("redirect has response", pend.size() > 0 && pend[0].due <= cyc);
    redirect_pc = 32'h200;
    redirect = 1'b1;
    tick();
    redirect = 1'b0;
    stall = 1'b0;
    words = 0;
    repeat (12) tick();
    chk_true("redirect progress", words >= 4);

    // Toggling grant with 3-cycle latency: no skip/duplicate, occupancy capped.
    do_reset();
    lat = 3; gnt_toggle = 1; exp_addr = 32'h0; grants = 0; words = 0; max_occ = 0;
    repeat (60) begin
      tick();
      occ = grants - words;
      if (occ > max_occ) max_occ = occ;
    end
    chk_true("occupancy <= 4", max_occ <= 4);
    chk_true("toggle progress", words >= 20);

    // Reset mid-stream with two requests outstanding.
    for (int g = 0; g < 40 && pend.size() != 2; g++) tick();
    chk_true("two outstanding before reset", pend.size() == 2);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst valid", 32'(valid_s2), 32'd0);
    chk("midrst inst", inst_s2, NOP_INST);
    chk("midrst pc4", pc4_s2, 32'h0);
    chk("midrst req", 32'(imem_req), 32'd0);
    pend.delete();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    inject_stale = 1;
    gnt_toggle = 0;
    exp_addr = 32'h0;
    words = 0;
    tick();
    chk("post-reset first grant", 32'(last_granted), 32'd1);
    chk("post-reset first addr", last_gaddr, 32'h0);
    repeat (8) tick();
    chk_true("post-reset progress", words >= 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
